seq_1011_tx: RTL

//  Serial frame transmitter: on a start request, emits sync word 1011 MSB-first, then a

---
 rtl/seq_1011_tx_pkg.sv | 14 +
 rtl/seq_1011_tx_if.sv | 14 +
 rtl/seq_1011_tx_piso_shift.sv | 21 ++
 rtl/seq_1011_tx.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/seq_1011_tx_pkg.sv
// Shared state encoding and default sync-word constants for the 1011-sync serial transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SYNC = 2'b01,
    DATA = 2'b10,
    PAR  = 2'b11
  } state_t;

  localparam int         DEF_SYNC_W    = 4;
  localparam logic [3:0] DEF_SYNC_WORD = 4'b1011;

endpackage

// File: rtl/seq_1011_tx_if.sv
// Frame request / serial output bundle between a frame source and the 1011-sync transmitter.
interface seq_1011_tx_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] data_in;
  logic              ready;
  logic              q;
  logic              q_valid;
  logic              done;

  modport master (output start, data_in, input ready, q, q_valid, done);
  modport slave  (input start, data_in, output ready, q, q_valid, done);
endinterface

// File: rtl/seq_1011_tx_piso_shift.sv
// Parallel-load, MSB-first shift register; load has priority over shift.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);
  logic [W-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst)        sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= sr << 1;
  end

  assign msb = sr[W-1];
endmodule

// File: rtl/seq_1011_tx.sv
// Serial frame transmitter: sync word then payload MSB-first, with busy/ready handshake.
// Optional trailing even-parity bit when SEQ_TX_PARITY_EN is defined.
module seq_1011_tx
  import seq_tx_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              SYNC_W    = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_W'(DEF_SYNC_WORD)
) (
  input  logic             clk,
  input  logic             rst,
  seq_1011_tx_if.slave     bus
);
`ifdef SEQ_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int   FRAME_L      = SYNC_W + DATA_W + PAR_BITS;
  localparam int   CNT_W        = $clog2(FRAME_L + 1);
  localparam logic LAST_IS_DATA = (PAR_BITS == 0);
  localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             q_reg, q_valid_reg, done_reg, ready_reg;
  logic             sr_msb, load_en, shift_en;
  logic             next_sync_bit;
`ifdef SEQ_TX_PARITY_EN
  logic             par;
`endif

  assign cnt_inc  = cnt + CNT_W'(1);
  assign load_en  = (state == IDLE) && bus.start;
  // a payload bit leaves the shifter on the same edge it is registered into q
  assign shift_en = ((state == SYNC) && (cnt == LAST_SYNC)) ||
                    ((state == DATA) && (cnt != LAST_DATA));

  always_comb begin
    next_sync_bit = 1'b0;
    for (int i = 0; i < SYNC_W; i++)
      if (i == SYNC_W - 2 - int'(cnt)) next_sync_bit = SYNC_WORD[i];
  end

  piso_shift #(.W(DATA_W)) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load_en),
    .shift (shift_en),
    .din   (bus.data_in),
    .msb   (sr_msb)
  );

  // cnt is the index of the bit currently on q within the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      q_reg       <= 1'b0;
      q_valid_reg <= 1'b0;
      done_reg    <= 1'b0;
      ready_reg   <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= SYNC;
            cnt         <= '0;
            q_reg       <= SYNC_WORD[SYNC_W-1];
            q_valid_reg <= 1'b1;
            ready_reg   <= 1'b0;
            done_reg    <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par         <= 1'b0;
`endif
          end
        end
        SYNC: begin
          if (cnt == LAST_SYNC) begin
            state    <= DATA;
            cnt      <= '0;
            q_reg    <= sr_msb;
            done_reg <= LAST_IS_DATA && (DATA_W == 1);
`ifdef SEQ_TX_PARITY_EN
            par      <= par ^ sr_msb;
`endif
          end else begin
            cnt   <= cnt_inc;
            q_reg <= next_sync_bit;
          end
        end
        DATA: begin
          if (cnt == LAST_DATA) begin
            cnt <= '0;
`ifdef SEQ_TX_PARITY_EN
            state    <= PAR;
            q_reg    <= par;
            done_reg <= 1'b1;
`else
            state       <= IDLE;
            q_reg       <= 1'b0;
            q_valid_reg <= 1'b0;
            done_reg    <= 1'b0;
            ready_reg   <= 1'b1;
`endif
          end else begin
            cnt      <= cnt_inc;
            q_reg    <= sr_msb;
            done_reg <= LAST_IS_DATA && (cnt_inc == LAST_DATA);
`ifdef SEQ_TX_PARITY_EN
            par      <= par ^ sr_msb;
`endif
          end
        end
        PAR: begin
          state       <= IDLE;
          cnt         <= '0;
          q_reg       <= 1'b0;
          q_valid_reg <= 1'b0;
          done_reg    <= 1'b0;
          ready_reg   <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          q_reg       <= 1'b0;
          q_valid_reg <= 1'b0;
          done_reg    <= 1'b0;
          ready_reg   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.q       = q_reg;
  assign bus.q_valid = q_valid_reg;
  assign bus.done    = done_reg;
  assign bus.ready   = ready_reg;
endmodule
